spi_crc_sched: RTL



---
 rtl/spi_crc_sched_pkg.sv | 17 +
 rtl/spi_rr_arbiter.sv | 42 ++++
 rtl/spi_crc_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_crc_sched_pkg.sv
// Shared definitions for the SPI-CRC link scheduler: state encoding and the
// link-facing defaults that must agree with the spi_crc master.
package spi_crc_sched_pkg;

  // Defaults shared with the spi_crc link.
  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_NUM_REQ    = 4;

  // Scheduler state encoding.
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_START = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: scans req_valid starting at rr_ptr and
// wrapping, returns a one-hot grant and its index. Reusable for any shared bus.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

  logic             found;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] slot;

  // First valid requester at or after rr_ptr (with wrap) wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    slot      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(off);
      if (sum >= NUM_REQ_S) begin
        sum = sum - NUM_REQ_S;
      end
      slot = sum[IDX_W-1:0];
      if (!found && req_valid[slot]) begin
        found       = 1'b1;
        grant       = '0;
        grant[slot] = 1'b1;
        grant_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/spi_crc_sched.sv
// Round-robin scheduler sharing one SPI-CRC master link between NUM_REQ
// requesters. One transfer at a time: accept, start pulse, wait for the
// finish rising edge (or time out), return the reply, then hold a gap so the
// link's slave select can return high before the next transfer.
module spi_crc_sched
  import spi_crc_sched_pkg::*;
#(
  parameter int NUM_REQ        = SPI_NUM_REQ,
  parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_m,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_finish,
  input  logic [DATA_WIDTH-1:0]         spi_data_out,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    cur_grant
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  // Timeout and gap share one counter, sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [ST_W-1:0]       state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic                  fin_prev_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  err_q;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  fin_edge;
  logic                  accept;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Only IDLE offers a grant; reset suppresses it so nothing is accepted
  // in the cycle the scheduler is being cleared.
  assign req_ready = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign fin_edge  = spi_finish & ~fin_prev_q;

  assign spi_start   = (state_q == ST_START);
  assign spi_data_in = tx_q;
  assign resp_valid  = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign resp_data   = rx_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign cur_grant   = grant_q;

  // Mux the granted requester's TX word out of the packed request bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer sequencing, round-robin pointer, finish edge history and the
  // shared timeout/gap counter.
  always_ff @(posedge clk_m) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      fin_prev_q <= 1'b0;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      // Tracked in every state so a finish level held from an earlier
      // transfer never looks like a fresh edge.
      fin_prev_q <= spi_finish;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx_q     <= sel_data;
            grant_q  <= arb_idx;
            rr_ptr_q <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A finish edge on the final count still counts as success.
          if (fin_edge) begin
            rx_q    <= spi_data_out;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (cnt_q == TO_LAST) begin
            rx_q    <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          cnt_q   <= '0;
          state_q <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
